// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Parametrised register file: DEPTH words of WIDTH bits, two combinational
//   read ports and one byte-masked write port. A write presented in a cycle is
//   visible on a matching read port in that same cycle (write-to-read bypass),
//   so the decode stage sees a value while it is being written back.
//   Entry 0 can be hardwired to zero (ZERO_REG=1).
//
// Parameters
//   WIDTH     word width in bits, multiple of 8
//   DEPTH     number of entries, power of two >= 2
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, clears every entry
//   writeEnable  write enable, active low
//   writeAddr    entry to write
//   writeMask    byte-lane enable, bit k covers writeData[8k+7:8k]
//   writeData    data to write
//   readAddr0/1  read port addresses
//   readData0/1  read port data (combinational, bypassed)
// -----------------------------------------------------------------------------
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writeEnable,
  input  logic [$clog2(DEPTH)-1:0] writeAddr,
  input  logic [WIDTH/8-1:0]       writeMask,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [$clog2(DEPTH)-1:0] readAddr0,
  output logic [WIDTH-1:0]         readData0,
  input  logic [$clog2(DEPTH)-1:0] readAddr1,
  output logic [WIDTH-1:0]         readData1
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LANES   = WIDTH / 8;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  // Reject illegal geometries at elaboration time.
  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : gBadWidth
      $error("register_file: WIDTH must be a positive multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
      $error("register_file: DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Overlay the enabled byte lanes of newWord onto oldWord.
  function automatic logic [WIDTH-1:0] mergeLanes(
    input logic [WIDTH-1:0] oldWord,
    input logic [WIDTH-1:0] newWord,
    input logic [LANES-1:0] mask
  );
    logic [WIDTH-1:0] result;
    result = oldWord;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        result[8*k +: 8] = newWord[8*k +: 8];
      end else begin
        result[8*k +: 8] = oldWord[8*k +: 8];
      end
    end
    return result;
  endfunction

  logic [WIDTH-1:0] memArray_r [DEPTH];

  logic writeToZero_s;
  logic writeCommit_s;
  logic bypassHit0_s;
  logic bypassHit1_s;
  logic zeroHit0_s;
  logic zeroHit1_s;

  // Decode write commit, bypass hits and zero-register hits.
  always_comb begin
    writeToZero_s = ZERO_EN && (writeAddr == {ADDR_W{1'b0}});
    writeCommit_s = !writeEnable && !writeToZero_s;
    // Bypass is suppressed during reset so reads show stored contents.
    bypassHit0_s  = !rst && !writeEnable && (writeAddr == readAddr0);
    bypassHit1_s  = !rst && !writeEnable && (writeAddr == readAddr1);
    zeroHit0_s    = ZERO_EN && (readAddr0 == {ADDR_W{1'b0}});
    zeroHit1_s    = ZERO_EN && (readAddr1 == {ADDR_W{1'b0}});
  end

  // Storage update: reset clears everything and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        memArray_r[i] <= {WIDTH{1'b0}};
      end
    end else if (writeCommit_s) begin
      memArray_r[writeAddr] <= mergeLanes(memArray_r[writeAddr], writeData, writeMask);
    end
  end

  // Read port 0: zero register first, then bypass merge, then stored word.
  always_comb begin
    readData0 = {WIDTH{1'b0}};
    if (zeroHit0_s) begin
      readData0 = {WIDTH{1'b0}};
    end else if (bypassHit0_s) begin
      readData0 = mergeLanes(memArray_r[readAddr0], writeData, writeMask);
    end else begin
      readData0 = memArray_r[readAddr0];
    end
  end

  // Read port 1: same priority as port 0, fully independent.
  always_comb begin
    readData1 = {WIDTH{1'b0}};
    if (zeroHit1_s) begin
      readData1 = {WIDTH{1'b0}};
    end else if (bypassHit1_s) begin
      readData1 = mergeLanes(memArray_r[readAddr1], writeData, writeMask);
    end else begin
      readData1 = memArray_r[readAddr1];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file. Three instances cover the
//   default geometry with ZERO_REG=1 (dutA), ZERO_REG=0 (dutB) and a
//   WIDTH=64 / DEPTH=8 geometry (dutC). Inputs change on the falling edge,
//   outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic clk;
  logic rst;

  // dutA: WIDTH=32, DEPTH=32, ZERO_REG=1
  logic        weA;
  logic [4:0]  waA;
  logic [3:0]  wmA;
  logic [31:0] wdA;
  logic [4:0]  ra0A, ra1A;
  logic [31:0] rd0A, rd1A;

  // dutB: WIDTH=32, DEPTH=4, ZERO_REG=0
  logic        weB;
  logic [1:0]  waB;
  logic [3:0]  wmB;
  logic [31:0] wdB;
  logic [1:0]  ra0B, ra1B;
  logic [31:0] rd0B, rd1B;

  // dutC: WIDTH=64, DEPTH=8, ZERO_REG=1
  logic        weC;
  logic [2:0]  waC;
  logic [7:0]  wmC;
  logic [63:0] wdC;
  logic [2:0]  ra0C, ra1C;
  logic [63:0] rd0C, rd1C;

  int checks;
  int errors;

  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst), .writeEnable(weA), .writeAddr(waA), .writeMask(wmA),
    .writeData(wdA), .readAddr0(ra0A), .readData0(rd0A), .readAddr1(ra1A),
    .readData1(rd1A)
  );

  register_file #(.WIDTH(32), .DEPTH(4), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .writeEnable(weB), .writeAddr(waB), .writeMask(wmB),
    .writeData(wdB), .readAddr0(ra0B), .readData0(rd0B), .readAddr1(ra1B),
    .readData1(rd1B)
  );

  register_file #(.WIDTH(64), .DEPTH(8), .ZERO_REG(1)) dutC (
    .clk(clk), .rst(rst), .writeEnable(weC), .writeAddr(waC), .writeMask(wmC),
    .writeData(wdC), .readAddr0(ra0C), .readData0(rd0C), .readAddr1(ra1C),
    .readData1(rd1C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-cycle write on dutA, no checking.
  task automatic wrA(input logic [4:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    weA = 1'b0; waA = a; wmA = m; wdA = d;
    @(posedge clk);
    #1 weA = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra0A = 5'(i * 9); ra1A = 5'(31 - i * 9);
      ra0B = 2'(i);     ra1B = 2'(3 - i);
      ra0C = 3'(i * 2); ra1C = 3'(7 - i * 2);
      #1;
      checks++;
      if (rd0A !== 32'h0 || rd1A !== 32'h0) begin
        errors++;
        $display("FAIL reset_A: got %h/%h expected 0/0", rd0A, rd1A);
      end
      checks++;
      if (rd0B !== 32'h0 || rd1B !== 32'h0) begin
        errors++;
        $display("FAIL reset_B: got %h/%h expected 0/0", rd0B, rd1B);
      end
      checks++;
      if (rd0C !== 64'h0 || rd1C !== 64'h0) begin
        errors++;
        $display("FAIL reset_C: got %h/%h expected 0/0", rd0C, rd1C);
      end
    end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    weA = 1'b0; waA = 5'd5; wmA = 4'b1111; wdA = 32'h12345678;
    ra0A = 5'd5; ra1A = 5'd6;
    #1;
    checks++;
    if (rd0A !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_bypass: got %h expected %h", rd0A, 32'h12345678);
    end
    checks++;
    if (rd1A !== 32'h0) begin
      errors++;
      $display("FAIL wr_other_addr: got %h expected %h", rd1A, 32'h0);
    end
    @(posedge clk);
    #1 weA = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rd0A !== 32'h12345678) begin
        errors++;
        $display("FAIL wr_stored: got %h expected %h", rd0A, 32'h12345678);
      end
    end
  endtask

  task automatic test_byte_mask;
    wrA(5'd7, 4'b1111, 32'hAABBCCDD);
    @(negedge clk);
    weA = 1'b0; waA = 5'd7; wmA = 4'b0101; wdA = 32'h11223344; ra1A = 5'd7;
    #1;
    checks++;
    if (rd1A !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL mask_bypass: got %h expected %h", rd1A, 32'hAA22CC44);
    end
    @(posedge clk);
    #1 weA = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd1A !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL mask_stored: got %h expected %h", rd1A, 32'hAA22CC44);
    end
    // All-zero mask is a no-op, both in bypass and after the edge.
    weA = 1'b0; wmA = 4'b0000; wdA = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rd1A !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL mask_zero_bypass: got %h expected %h", rd1A, 32'hAA22CC44);
    end
    @(posedge clk);
    #1 weA = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd1A !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL mask_zero_stored: got %h expected %h", rd1A, 32'hAA22CC44);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    weA = 1'b0; waA = 5'd0; wmA = 4'b1111; wdA = 32'hFFFFFFFF;
    ra0A = 5'd0; ra1A = 5'd0;
    weB = 1'b0; waB = 2'd0; wmB = 4'b1111; wdB = 32'hFFFFFFFF; ra0B = 2'd0;
    #1;
    checks++;
    if (rd0A !== 32'h0 || rd1A !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: got %h/%h expected 0/0", rd0A, rd1A);
    end
    checks++;
    if (rd0B !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL nozero_bypass: got %h expected %h", rd0B, 32'hFFFFFFFF);
    end
    @(posedge clk);
    #1 weA = 1'b1; weB = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd0A !== 32'h0 || rd1A !== 32'h0) begin
      errors++;
      $display("FAIL zero_stored: got %h/%h expected 0/0", rd0A, rd1A);
    end
    checks++;
    if (rd0B !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL nozero_stored: got %h expected %h", rd0B, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_reset_collision;
    wrA(5'd3, 4'b1111, 32'h000000AA);
    @(negedge clk);
    rst = 1'b1; weA = 1'b0; waA = 5'd3; wmA = 4'b1111; wdA = 32'h00000055;
    ra0A = 5'd3;
    #1;
    checks++;
    if (rd0A !== 32'h000000AA) begin
      errors++;
      $display("FAIL collide_no_bypass: got %h expected %h", rd0A, 32'h000000AA);
    end
    @(posedge clk);
    #1 rst = 1'b0; weA = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd0A !== 32'h0) begin
      errors++;
      $display("FAIL collide_after: got %h expected %h", rd0A, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    weA = 1'b0; waA = 5'd9; wmA = 4'b1111; wdA = 32'h11111111;
    ra0A = 5'd9; ra1A = 5'd9;
    @(posedge clk);
    #1 wmA = 4'b0011; wdA = 32'h22222222;
    @(negedge clk);
    #1;
    checks++;
    if (rd0A !== 32'h11112222 || rd1A !== 32'h11112222) begin
      errors++;
      $display("FAIL b2b_bypass: got %h/%h expected %h", rd0A, rd1A, 32'h11112222);
    end
    @(posedge clk);
    #1 weA = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd0A !== 32'h11112222) begin
      errors++;
      $display("FAIL b2b_stored: got %h expected %h", rd0A, 32'h11112222);
    end
  endtask

  task automatic test_reset_clear;
    for (int a = 1; a < 32; a++) begin
      wrA(5'(a), 4'b1111, 32'hDEADBEEF);
    end
    @(negedge clk);
    ra0A = 5'd31;
    #1;
    checks++;
    if (rd0A !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL clear_pre: got %h expected %h", rd0A, 32'hDEADBEEF);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      ra0A = 5'(a); ra1A = 5'(31 - a);
      #1;
      checks++;
      if (rd0A !== 32'h0 || rd1A !== 32'h0) begin
        errors++;
        $display("FAIL clear_addr%0d: got %h/%h expected 0/0", a, rd0A, rd1A);
      end
    end
  endtask

  task automatic test_param_sweep;
    @(negedge clk);
    weC = 1'b0; waC = 3'd6; wmC = 8'hF0; wdC = 64'h0123456789ABCDEF;
    ra0C = 3'd6; ra1C = 3'd6;
    #1;
    checks++;
    if (rd0C !== 64'h0123456700000000 || rd1C !== 64'h0123456700000000) begin
      errors++;
      $display("FAIL sweep_bypass: got %h/%h expected %h", rd0C, rd1C, 64'h0123456700000000);
    end
    @(posedge clk);
    #1 weC = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd0C !== 64'h0123456700000000 || rd1C !== 64'h0123456700000000) begin
      errors++;
      $display("FAIL sweep_stored: got %h/%h expected %h", rd0C, rd1C, 64'h0123456700000000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    weA = 1'b1; waA = 5'd0; wmA = 4'b0000; wdA = 32'h0; ra0A = 5'd0; ra1A = 5'd0;
    weB = 1'b1; waB = 2'd0; wmB = 4'b0000; wdB = 32'h0; ra0B = 2'd0; ra1B = 2'd0;
    weC = 1'b1; waC = 3'd0; wmC = 8'h00;   wdC = 64'h0; ra0C = 3'd0; ra1C = 3'd0;

    test_reset();
    test_write_read();
    test_byte_mask();
    test_zero_reg();
    test_reset_collision();
    test_back_to_back();
    test_reset_clear();
    test_param_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
